fit_input_gen: RTL and testbench
================================

FIT_INPUT_GEN -- requirements
Module: fit_input_gen

Interface
REQ-001 Parameter NCH, default 2: number of residual input channels, 1..8.
REQ-002 Parameter WIDTH, default 36: residual word width.
REQ-003 Parameter AW, default 6: channel memory address width.
REQ-004 Parameter DEPTH_LOG2, default 6: output FIFO depth is 2**DEPTH_LOG2.
REQ-005 Parameter START_DELAY, default 5: cycles from start to the automatic first pop.
REQ-006 clk  in  1  single clock; all logic on the rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 start  in  1  one-cycle event start pulse.
REQ-009 read_en  in  1  downstream pop request.
REQ-010 number  in  NCH*AW  per-channel word count; channel k is in slice [k*AW +: AW].
REQ-011 addr  out  NCH*AW  per-channel registered read address.
REQ-012 res_input  in  NCH*WIDTH  per-channel memory data, one-cycle read latency.
REQ-013 res_output  out  WIDTH  registered popped word.
REQ-014 valid  out  1  res_output holds a newly popped word this cycle.
REQ-015 empty, full  out  1 each  FIFO status.
REQ-016 count  out  DEPTH_LOG2+1  FIFO occupancy.
REQ-017 overflow  out  1  sticky flag: a word was dropped.

Function
REQ-018 The scan FSM SHALL have states IDLE, SCAN and DONE; DONE returns to IDLE after one cycle.
REQ-019 When start is sampled high, the block SHALL:
- enter SCAN at channel 0, address 0;
- flush the FIFO (count=0);
- clear overflow;
- arm the auto-pop delay.
REQ-020 In SCAN, the block SHALL issue addresses 0..number[k]-1 on addr[k], one per cycle, then move to channel k+1.
REQ-021 All addresses of idle channels SHALL read all-ones.
REQ-022 A channel with number[k]=0 SHALL be skipped in exactly one cycle with no address issued.
REQ-023 After the last channel finishes, the FSM SHALL go to DONE.
REQ-024 number SHALL be sampled per channel at the point that channel is entered.
REQ-025 Data for an issued address SHALL be taken from res_input slice k one cycle after issue.
REQ-026 A non-zero word SHALL be pushed on the following edge; all-zero words SHALL be discarded.
REQ-027 Push order SHALL be channel-ascending, then address-ascending.
REQ-028 Pop conditions:
- a pop occurs when read_en=1, or on the single auto-pop cycle START_DELAY cycles after start;
- a pop requires empty=0.
REQ-029 On a pop, res_output SHALL load the head word and valid SHALL be 1 on the next cycle.
REQ-030 When no pop occurs, valid SHALL be 0 and res_output SHALL hold its value.
REQ-031 A pop on an empty FIFO SHALL be a no-op.
REQ-032 Simultaneous push and pop SHALL both take effect, leaving count unchanged, including when full=1.
REQ-033 A push while full=1 with no pop SHALL drop the word and set overflow.
REQ-034 overflow SHALL stay set until the next start or reset.
REQ-035 FIFO pointers SHALL wrap modulo 2**DEPTH_LOG2.
REQ-036 full SHALL equal (count==2**DEPTH_LOG2); empty SHALL equal (count==0).
REQ-037 A start during SCAN SHALL abort the scan and restart per REQ-019; in-flight read data from the aborted scan SHALL be discarded.

Reset
REQ-038 On reset the block SHALL set:
- FSM=IDLE;
- all addr slices all-ones;
- count=0, empty=1, full=0, overflow=0;
- valid=0, res_output=0;
- auto-pop disarmed.
REQ-039 Reset SHALL take priority over start and read_en in the same cycle, including mid-scan.

Verification
REQ-040 NCH=2; number={0:3, 1:2}; all words non-zero; start at edge E0; no read_en.
- Required: addr0=0,1,2 after E0..E2, then addr1=0,1.
- Required: count reaches 5.
- Required: auto-pop gives valid=1 with the channel-0 address-0 word after E(START_DELAY+1).
REQ-041 Channel-0 words {A,0,B}, with words read one cycle after each address is issued.
- Required: only A and B are pushed; count=2.
REQ-042 number[0]=0, number[1]=1.
- Required: channel 0 is skipped in one cycle; addr1=0 is issued after E1.
REQ-043 DEPTH_LOG2=2; 6 non-zero words; no pops.
- Required: full=1 at count=4; overflow=1; later pops return the first 4 words in order.
REQ-044 start asserted again mid-scan.
- Required: count=0 next cycle; the scan restarts at channel 0, address 0; no stale word is pushed.
REQ-045 reset asserted mid-scan with read_en=1.
- Required: all outputs take REQ-038 values next cycle.

Source files
------------

// File: rtl/fit_input_gen_if.sv
// Bundle between fit_input_gen and its surroundings: event start, per-channel
// residual memory ports and the popped-word output with FIFO status.
interface fit_input_gen_if #(
    parameter int NCH        = 2,
    parameter int WIDTH      = 36,
    parameter int AW         = 6,
    parameter int DEPTH_LOG2 = 6
);
    logic                   start;
    logic                   read_en;
    logic [NCH*AW-1:0]      number;
    logic [NCH*AW-1:0]      addr;
    logic [NCH*WIDTH-1:0]   res_input;
    logic [WIDTH-1:0]       res_output;
    logic                   valid;
    logic                   empty;
    logic                   full;
    logic [DEPTH_LOG2:0]    count;
    logic                   overflow;

    modport master (
        output start, read_en, number, res_input,
        input  addr, res_output, valid, empty, full, count, overflow
    );

    modport slave (
        input  start, read_en, number, res_input,
        output addr, res_output, valid, empty, full, count, overflow
    );
endinterface

// File: rtl/fit_input_gen.sv
// Scans NCH residual memories, pushes non-zero words into a FIFO (push one edge after issue, pop result one edge after request).
// No backpressure upstream: a push into a full FIFO without a simultaneous pop is dropped and flagged sticky overflow.
module fit_input_gen #(
    parameter int NCH         = 2,
    parameter int WIDTH       = 36,
    parameter int AW          = 6,
    parameter int DEPTH_LOG2  = 6,
    parameter int START_DELAY = 5
) (
    input  logic           clk,
    input  logic           reset,
    fit_input_gen_if.slave bus
);
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int DW    = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [AW-1:0]    num_arr [NCH];
    logic [WIDTH-1:0] res_arr [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign num_arr[k] = bus.number[k*AW +: AW];
        assign res_arr[k] = bus.res_input[k*WIDTH +: WIDTH];
    end

    logic [1:0]              state, nxt_state;
    logic [CW-1:0]           ch, nxt_ch;
    logic [AW-1:0]           cur_addr, nxt_addr;
    logic [AW-1:0]           cur_num, nxt_num;
    logic                    nxt_issue;
    logic [NCH-1:0][AW-1:0]  addr_q;
    logic                    rd_vld;
    logic [CW-1:0]           rd_ch;

    // Entering a channel issues its address 0 on the same edge, so an empty
    // channel costs exactly one cycle with every address slice at all-ones.
    always_comb begin
        nxt_state = state;
        nxt_ch    = ch;
        nxt_addr  = cur_addr;
        nxt_num   = cur_num;
        if (bus.start) begin
            nxt_state = S_SCAN;
            nxt_ch    = '0;
            nxt_addr  = '0;
            nxt_num   = num_arr[0];
        end else begin
            case (state)
                S_SCAN: begin
                    if (cur_num != '0 && cur_addr != cur_num - AW'(1)) begin
                        nxt_addr = cur_addr + AW'(1);
                    end else if (ch == CW'(NCH - 1)) begin
                        nxt_state = S_DONE;
                    end else begin
                        nxt_ch   = ch + CW'(1);
                        nxt_addr = '0;
                        nxt_num  = num_arr[nxt_ch];
                    end
                end
                S_DONE:  nxt_state = S_IDLE;
                default: nxt_state = state;
            endcase
        end
        nxt_issue = (nxt_state == S_SCAN) && (nxt_num != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ch       <= '0;
            cur_addr <= '0;
            cur_num  <= '0;
            addr_q   <= '1;
            rd_vld   <= 1'b0;
            rd_ch    <= '0;
        end else begin
            state    <= nxt_state;
            ch       <= nxt_ch;
            cur_addr <= nxt_addr;
            cur_num  <= nxt_num;
            for (int k = 0; k < NCH; k++) begin
                addr_q[k] <= (nxt_issue && nxt_ch == CW'(k)) ? nxt_addr : '1;
            end
            rd_vld   <= nxt_issue;
            rd_ch    <= nxt_ch;
        end
    end

    // A start on the same edge discards the word still in flight from the old scan.
    logic [WIDTH-1:0] push_dat;
    logic             push_req;
    assign push_dat = res_arr[rd_ch];
    assign push_req = rd_vld && (push_dat != '0) && !bus.start;

    logic          armed;
    logic [DW-1:0] dly;
    logic          auto_pop;
    assign auto_pop = armed && (dly == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            armed <= 1'b0;
            dly   <= '0;
        end else if (bus.start) begin
            armed <= 1'b1;
            dly   <= DW'(START_DELAY);
        end else if (armed) begin
            if (dly == '0) begin
                armed <= 1'b0;
            end else begin
                dly <= dly - DW'(1);
            end
        end
    end

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  ovf_q;
    logic                  out_vld;
    logic [WIDTH-1:0]      out_dat;
    logic                  full, empty, pop, push_ok;

    assign full    = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop     = (bus.read_en || auto_pop) && !empty && !bus.start;
    assign push_ok = push_req && (!full || pop);

    // The head is read before the write lands, so push+pop while full is safe.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (bus.start) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= pop;
            if (pop) begin
                out_dat <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + DEPTH_LOG2'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
            end else if (pop && !push_ok) begin
                count_q <= count_q - (DEPTH_LOG2 + 1)'(1);
            end
            if (push_req && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.addr       = addr_q;
    assign bus.res_output = out_dat;
    assign bus.valid      = out_vld;
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.count      = count_q;
    assign bus.overflow   = ovf_q;

    logic [NCH-1:0] slice_act;
    always_comb begin
        slice_act = '0;
        for (int k = 0; k < NCH; k++) begin
            slice_act[k] = (addr_q[k] != '1);
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count_q <= (DEPTH_LOG2 + 1)'(DEPTH));
    a_one_channel: assert property (@(posedge clk) disable iff (reset)
        $onehot0(slice_act));
endmodule

// File: tb/tb_fit_input_gen.sv
// Directed bench: two instances (deep FIFO / 4-entry FIFO) fed by combinational
// memory models addressed by the registered addr outputs.
module tb_fit_input_gen;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fit_input_gen_if #(.NCH(2), .WIDTH(36), .AW(6), .DEPTH_LOG2(6)) ifa ();
    fit_input_gen_if #(.NCH(2), .WIDTH(36), .AW(6), .DEPTH_LOG2(2)) ifb ();

    logic [35:0] mem_a [2][64];
    logic [35:0] mem_b [2][64];

    always_comb begin
        ifa.res_input = '0;
        ifb.res_input = '0;
        for (int c = 0; c < 2; c++) begin
            ifa.res_input[c*36 +: 36] = mem_a[c][ifa.addr[c*6 +: 6]];
            ifb.res_input[c*36 +: 36] = mem_b[c][ifb.addr[c*6 +: 6]];
        end
    end

    fit_input_gen #(.NCH(2), .WIDTH(36), .AW(6), .DEPTH_LOG2(6), .START_DELAY(5)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    fit_input_gen #(.NCH(2), .WIDTH(36), .AW(6), .DEPTH_LOG2(2), .START_DELAY(20)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] w(input int c, input int a);
        return 36'h9_0000_0000 | (36'(c + 1) << 8) | 36'(a + 1);
    endfunction

    function automatic logic [11:0] ad(input int a1, input int a0);
        return {6'(a1), 6'(a0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a();
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
    endtask

    task automatic pulse_b();
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
    endtask

    logic [35:0] exp_q [4];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        ifa.start = 1'b0; ifa.read_en = 1'b0; ifa.number = '0;
        ifb.start = 1'b0; ifb.read_en = 1'b0; ifb.number = '0;
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 64; a++) begin
                mem_a[c][a] = w(c, a);
                mem_b[c][a] = w(c, a);
            end
        end
        repeat (3) tick();
        check("rst addr", ifa.addr, 12'hFFF);
        check("rst count", ifa.count, 0);
        check("rst empty", ifa.empty, 1);
        check("rst full", ifa.full, 0);
        check("rst ovf", ifa.overflow, 0);
        check("rst valid", ifa.valid, 0);
        check("rst res", ifa.res_output, 0);
        check("rst addr b", ifb.addr, 12'hFFF);
        reset = 1'b0;
        tick();

        // basic scan {3,2}, auto-pop, then drain with read_en
        ifa.number = {6'd2, 6'd3};
        pulse_a();
        check("t1 addr e0", ifa.addr, ad(63, 0));
        tick(); check("t1 addr e1", ifa.addr, ad(63, 1)); check("t1 cnt e1", ifa.count, 1);
        tick(); check("t1 addr e2", ifa.addr, ad(63, 2)); check("t1 cnt e2", ifa.count, 2);
        tick(); check("t1 addr e3", ifa.addr, ad(0, 63)); check("t1 cnt e3", ifa.count, 3);
        tick(); check("t1 addr e4", ifa.addr, ad(1, 63)); check("t1 cnt e4", ifa.count, 4);
        tick(); check("t1 addr e5", ifa.addr, 12'hFFF);  check("t1 cnt e5", ifa.count, 5);
        check("t1 valid e5", ifa.valid, 0);
        tick(); check("t1 autopop vld", ifa.valid, 1); check("t1 autopop res", ifa.res_output, w(0, 0));
        check("t1 cnt e6", ifa.count, 4);
        tick(); check("t1 vld e7", ifa.valid, 0); check("t1 hold e7", ifa.res_output, w(0, 0));
        exp_q[0] = w(0, 1); exp_q[1] = w(0, 2); exp_q[2] = w(1, 0); exp_q[3] = w(1, 1);
        ifa.read_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1 pop vld", ifa.valid, 1);
            check("t1 pop res", ifa.res_output, exp_q[i]);
        end
        tick();
        check("t1 empty pop vld", ifa.valid, 0);
        check("t1 empty pop res", ifa.res_output, w(1, 1));
        check("t1 empty cnt", ifa.count, 0);
        check("t1 empty flag", ifa.empty, 1);
        ifa.read_en = 1'b0;

        // zero word discarded: ch0 = {A,0,B}, ch1 empty
        mem_a[0][1] = '0;
        ifa.number = {6'd0, 6'd3};
        pulse_a();
        tick(); check("t2 cnt e1", ifa.count, 1);
        tick(); check("t2 cnt e2", ifa.count, 1);
        tick(); check("t2 cnt e3", ifa.count, 2); check("t2 addr e3", ifa.addr, 12'hFFF);
        tick(); tick(); check("t2 cnt e5", ifa.count, 2);
        tick(); check("t2 autopop vld", ifa.valid, 1); check("t2 autopop res", ifa.res_output, w(0, 0));
        ifa.read_en = 1'b1;
        tick(); check("t2 pop res", ifa.res_output, w(0, 2)); check("t2 cnt e7", ifa.count, 0);
        ifa.read_en = 1'b0;
        mem_a[0][1] = w(0, 1);

        // empty channel 0 skipped in one cycle
        ifa.number = {6'd1, 6'd0};
        pulse_a();
        check("t3 addr e0", ifa.addr, 12'hFFF);
        tick(); check("t3 addr e1", ifa.addr, ad(0, 63));
        tick(); check("t3 addr e2", ifa.addr, 12'hFFF); check("t3 cnt e2", ifa.count, 1);
        repeat (4) tick();
        check("t3 autopop vld", ifa.valid, 1); check("t3 autopop res", ifa.res_output, w(1, 0));
        check("t3 cnt e6", ifa.count, 0);

        // restart mid-scan
        ifa.number = {6'd2, 6'd3};
        pulse_a();
        tick(); tick();
        check("t4 cnt pre", ifa.count, 2); check("t4 addr pre", ifa.addr, ad(63, 2));
        pulse_a();
        check("t4 cnt flush", ifa.count, 0); check("t4 addr restart", ifa.addr, ad(63, 0));
        tick(); check("t4 cnt e4", ifa.count, 1); check("t4 addr e4", ifa.addr, ad(63, 1));
        repeat (5) tick();
        check("t4 autopop vld", ifa.valid, 1); check("t4 autopop res", ifa.res_output, w(0, 0));
        check("t4 cnt e9", ifa.count, 4);

        // reset mid-scan with read_en and start held
        pulse_a();
        tick(); check("t5 cnt e1", ifa.count, 1);
        ifa.read_en = 1'b1;
        tick(); check("t5 vld e2", ifa.valid, 1); check("t5 res e2", ifa.res_output, w(0, 0));
        reset = 1'b1; ifa.start = 1'b1;
        tick();
        check("t5 rst addr", ifa.addr, 12'hFFF);
        check("t5 rst cnt", ifa.count, 0);
        check("t5 rst empty", ifa.empty, 1);
        check("t5 rst full", ifa.full, 0);
        check("t5 rst ovf", ifa.overflow, 0);
        check("t5 rst vld", ifa.valid, 0);
        check("t5 rst res", ifa.res_output, 0);
        reset = 1'b0; ifa.start = 1'b0; ifa.read_en = 1'b0;
        repeat (8) tick();
        check("t5 idle addr", ifa.addr, 12'hFFF);
        check("t5 idle cnt", ifa.count, 0);

        // 4-entry FIFO overflow, no pops
        ifb.number = {6'd3, 6'd3};
        pulse_b();
        repeat (4) tick();
        check("t6 cnt e4", ifb.count, 4); check("t6 full e4", ifb.full, 1);
        check("t6 ovf e4", ifb.overflow, 0);
        tick(); check("t6 cnt e5", ifb.count, 4); check("t6 ovf e5", ifb.overflow, 1);
        tick(); tick();
        exp_q[0] = w(0, 0); exp_q[1] = w(0, 1); exp_q[2] = w(0, 2); exp_q[3] = w(1, 0);
        ifb.read_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6 pop res", ifb.res_output, exp_q[i]);
        end
        ifb.read_en = 1'b0;
        check("t6 empty", ifb.empty, 1); check("t6 ovf sticky", ifb.overflow, 1);

        // push and pop together while full
        pulse_b();
        check("t7 ovf cleared", ifb.overflow, 0); check("t7 cnt e0", ifb.count, 0);
        repeat (4) tick();
        check("t7 full e4", ifb.full, 1);
        ifb.read_en = 1'b1;
        tick();
        check("t7 cnt e5", ifb.count, 4); check("t7 ovf e5", ifb.overflow, 0);
        check("t7 vld e5", ifb.valid, 1); check("t7 res e5", ifb.res_output, w(0, 0));
        ifb.read_en = 1'b0;
        tick(); check("t7 ovf e6", ifb.overflow, 1); check("t7 cnt e6", ifb.count, 4);
        exp_q[0] = w(0, 1); exp_q[1] = w(0, 2); exp_q[2] = w(1, 0); exp_q[3] = w(1, 1);
        ifb.read_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t7 pop res", ifb.res_output, exp_q[i]);
        end
        ifb.read_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
